// File: rtl/mult_radix16_seq_pkg.sv
// Shared definitions for the radix-16 sequential multiplier: FSM states and digit width.
package mult_radix16_seq_pkg;
  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;
endpackage

// File: rtl/mult_digit_sel.sv
// Picks the 4-bit multiplier digit addressed by the digit counter.
module mult_digit_sel
  import mult_radix16_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 3
) (
  input  logic [WIDTH-1:0]   breg,
  input  logic [CNT_W-1:0]   cnt,
  output logic [DIGIT_W-1:0] d
);

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = breg >> (DIGIT_W * cnt);
    d       = shifted[DIGIT_W-1:0];
  end

endmodule

// File: rtl/mult_radix16_seq.sv
// Sequential multiplier consuming one radix-16 digit of B per cycle.
// Define MULT_SIGNED_EN to add the Signed port and two's-complement operand handling.
module mult_radix16_seq
  import mult_radix16_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
`ifdef MULT_SIGNED_EN
  input  logic               Signed,
`endif
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Product
);

  localparam int NDIG  = WIDTH / DIGIT_W;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   areg_q, areg_d;
  logic [WIDTH-1:0]   breg_q, breg_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] product_q, product_d;
`ifdef MULT_SIGNED_EN
  logic               neg_q, neg_d;
`endif

  logic [DIGIT_W-1:0] digit;
  logic [2*WIDTH-1:0] pp;
  logic [2*WIDTH-1:0] acc_sum;
  logic [2*WIDTH-1:0] result;

  mult_digit_sel #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_digit_sel (
    .breg(breg_q),
    .cnt (cnt_q),
    .d   (digit)
  );

  always_comb begin
    pp      = ({{WIDTH{1'b0}}, areg_q} * {{(2*WIDTH-DIGIT_W){1'b0}}, digit}) << (DIGIT_W * cnt_q);
    acc_sum = acc_q + pp;
    result  = acc_sum;
`ifdef MULT_SIGNED_EN
    if (neg_q) result = -acc_sum;
`endif
  end

  always_comb begin
    state_d   = state_q;
    areg_d    = areg_q;
    breg_d    = breg_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;
`ifdef MULT_SIGNED_EN
    neg_d     = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (Start) begin
          areg_d  = A;
          breg_d  = B;
`ifdef MULT_SIGNED_EN
          // Operands are stored as magnitudes; -2^(WIDTH-1) negates to itself, read unsigned.
          neg_d = 1'b0;
          if (Signed) begin
            if (A[WIDTH-1]) areg_d = -A;
            if (B[WIDTH-1]) breg_d = -B;
            neg_d = A[WIDTH-1] ^ B[WIDTH-1];
          end
`endif
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          product_d = result;
          busy_d    = 1'b0;
          state_d   = FIN;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      areg_q    <= '0;
      breg_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
`ifdef MULT_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      areg_q    <= areg_d;
      breg_q    <= breg_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
`ifdef MULT_SIGNED_EN
      neg_q     <= neg_d;
`endif
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Product = product_q;

endmodule
